// File: rtl/chip_cmd_sequencer.sv
// Command sequencer: pops host command words from FIFO A, drives the shared SPI/I2C request
// port, waits on chip status or delays, and posts responses to FIFO B. Optional: SEQ_TIMEOUT_EN.
module chip_cmd_sequencer #(
  parameter int TIMEOUT_W = 24,
  parameter int CMD_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 run,
  input  logic [31:0]          FIFOA_OUT,
  input  logic                 FIFOA_empty,
  output logic                 FIFOA_ren,
  output logic [31:0]          FIFOB_IN,
  output logic                 FIFOB_wen,
  input  logic                 FIFOB_full,
  input  logic                 sta_wei,
  input  logic                 sta_act,
  output logic                 ser_start,
  output logic                 ser_sel,
  output logic                 ser_rw,
  output logic [7:0]           ser_addr,
  output logic [15:0]          ser_wdata,
  input  logic                 ser_busy,
  input  logic                 ser_done,
  input  logic [15:0]          ser_rdata,
  output logic                 busy,
  output logic [CMD_CNT_W-1:0] cmd_cnt
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_ISSUE     = 4'd3;
  localparam logic [3:0] S_WAIT_XFER = 4'd4;
  localparam logic [3:0] S_WAIT_STA  = 4'd5;
  localparam logic [3:0] S_DELAY     = 4'd6;
  localparam logic [3:0] S_PUSH      = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  localparam logic [3:0] OP_WRITE    = 4'h1;
  localparam logic [3:0] OP_READ     = 4'h2;
  localparam logic [3:0] OP_WAIT_WEI = 4'h3;
  localparam logic [3:0] OP_WAIT_ACT = 4'h4;
  localparam logic [3:0] OP_DELAY    = 4'h5;
  localparam logic [3:0] OP_MARK     = 4'hF;

  logic [3:0]           state_reg, state_next;
  logic                 ren_reg, ren_next;
  logic                 wen_reg, wen_next;
  logic                 start_reg, start_next;
  logic                 sel_reg, sel_next;
  logic                 rw_reg, rw_next;
  logic [7:0]           addr_reg, addr_next;
  logic [15:0]          wdata_reg, wdata_next;
  logic [31:0]          resp_reg, resp_next;
  logic [3:0]           op_reg, op_next;
  logic [TIMEOUT_W-1:0] payload_reg, payload_next;
  logic [TIMEOUT_W-1:0] cnt_reg, cnt_next;
  logic [CMD_CNT_W-1:0] cmd_cnt_reg, cmd_cnt_next;

  logic [1:0]  sta_raw, sta_sync;
  logic        sta_hit;
  logic [3:0]  fetch_op;
  logic [15:0] cnt16;

  assign sta_raw  = {sta_act, sta_wei};
  assign fetch_op = FIFOA_OUT[31:28];
  assign cnt16    = 16'(cmd_cnt_reg);
  assign sta_hit  = (op_reg == OP_WAIT_ACT) ? sta_sync[1] : sta_sync[0];

  // Status lines come straight from the chip pads, so each gets its own two-flop synchroniser.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sta_sync
    logic meta_reg, sync_reg;
    always_ff @(posedge CLK) begin
      if (rst) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= sta_raw[gi];
        sync_reg <= meta_reg;
      end
    end
    assign sta_sync[gi] = sync_reg;
  end

  always_comb begin
    state_next   = state_reg;
    ren_next     = 1'b0;
    wen_next     = 1'b0;
    start_next   = 1'b0;
    sel_next     = sel_reg;
    rw_next      = rw_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    resp_next    = resp_reg;
    op_next      = op_reg;
    payload_next = payload_reg;
    cnt_next     = cnt_reg;
    cmd_cnt_next = cmd_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (run && !FIFOA_empty) begin
          ren_next   = 1'b1;
          state_next = S_FETCH;
        end
      end
      // FIFO A word appears the cycle after the read strobe, i.e. while in DECODE.
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        op_next      = fetch_op;
        payload_next = FIFOA_OUT[TIMEOUT_W-1:0];
        cnt_next     = TIMEOUT_W'(1);
        case (fetch_op)
          OP_WRITE, OP_READ: begin
            sel_next   = FIFOA_OUT[27];
            rw_next    = (fetch_op == OP_READ);
            addr_next  = FIFOA_OUT[23:16];
            wdata_next = FIFOA_OUT[15:0];
            state_next = S_ISSUE;
          end
          OP_WAIT_WEI, OP_WAIT_ACT: state_next = S_WAIT_STA;
          OP_DELAY:                 state_next = S_DELAY;
          OP_MARK: begin
            resp_next  = {4'hF, FIFOA_OUT[27:0]};
            state_next = S_PUSH;
          end
          default: begin
            resp_next  = {4'hE, 4'h1, 8'h00, cnt16};
            state_next = S_PUSH;
          end
        endcase
      end
      S_ISSUE: begin
        if (!ser_busy) begin
          start_next = 1'b1;
          cnt_next   = TIMEOUT_W'(1);
          state_next = S_WAIT_XFER;
        end
      end
      S_WAIT_XFER: begin
        if (ser_done) begin
          if (op_reg == OP_READ) begin
            resp_next  = {4'h2, 4'h0, addr_reg, ser_rdata};
            state_next = S_PUSH;
          end else begin
            state_next = S_DONE;
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (&cnt_reg) begin
          resp_next  = {4'hE, 4'h3, 8'h00, cnt16};
          state_next = S_PUSH;
        end else begin
          cnt_next = cnt_reg + TIMEOUT_W'(1);
        end
`endif
      end
      S_WAIT_STA: begin
        if (sta_hit) begin
          state_next = S_DONE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if ((payload_reg != '0) && (cnt_reg >= payload_reg)) begin
          resp_next  = {4'hE, 4'h2, 8'h00, cnt16};
          state_next = S_PUSH;
        end else begin
          cnt_next = cnt_reg + TIMEOUT_W'(1);
        end
`endif
      end
      // cnt_reg counts DELAY cycles including the current one, so payload 0 and 1 both take one cycle.
      S_DELAY: begin
        if (cnt_reg >= payload_reg) state_next = S_DONE;
        else                        cnt_next   = cnt_reg + TIMEOUT_W'(1);
      end
      S_PUSH: begin
        if (!FIFOB_full) begin
          wen_next   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        cmd_cnt_next = cmd_cnt_reg + CMD_CNT_W'(1);
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      ren_reg     <= 1'b0;
      wen_reg     <= 1'b0;
      start_reg   <= 1'b0;
      sel_reg     <= 1'b0;
      rw_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      resp_reg    <= '0;
      op_reg      <= '0;
      payload_reg <= '0;
      cnt_reg     <= '0;
      cmd_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ren_reg     <= ren_next;
      wen_reg     <= wen_next;
      start_reg   <= start_next;
      sel_reg     <= sel_next;
      rw_reg      <= rw_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      resp_reg    <= resp_next;
      op_reg      <= op_next;
      payload_reg <= payload_next;
      cnt_reg     <= cnt_next;
      cmd_cnt_reg <= cmd_cnt_next;
    end
  end

  assign FIFOA_ren = ren_reg;
  assign FIFOB_wen = wen_reg;
  assign FIFOB_IN  = resp_reg;
  assign ser_start = start_reg;
  assign ser_sel   = sel_reg;
  assign ser_rw    = rw_reg;
  assign ser_addr  = addr_reg;
  assign ser_wdata = wdata_reg;
  assign busy      = (state_reg != S_IDLE);
  assign cmd_cnt   = cmd_cnt_reg;

endmodule

// File: tb/tb_chip_cmd_sequencer.sv
// Scoreboard bench for chip_cmd_sequencer: FIFO A model, stub serial master, and a monitor
// that checks every FIFO B write and serial request against queued expectations.
module tb_chip_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        rst, run;
  logic [31:0] FIFOA_OUT;
  logic        FIFOA_empty, FIFOA_ren;
  logic [31:0] FIFOB_IN;
  logic        FIFOB_wen, FIFOB_full;
  logic        sta_wei, sta_act;
  logic        ser_start, ser_sel, ser_rw;
  logic [7:0]  ser_addr;
  logic [15:0] ser_wdata;
  logic        ser_busy, ser_done;
  logic [15:0] ser_rdata;
  logic        busy;
  logic [15:0] cmd_cnt;

  always #5 CLK = ~CLK;

  chip_cmd_sequencer dut (
    .CLK(CLK), .rst(rst), .run(run),
    .FIFOA_OUT(FIFOA_OUT), .FIFOA_empty(FIFOA_empty), .FIFOA_ren(FIFOA_ren),
    .FIFOB_IN(FIFOB_IN), .FIFOB_wen(FIFOB_wen), .FIFOB_full(FIFOB_full),
    .sta_wei(sta_wei), .sta_act(sta_act),
    .ser_start(ser_start), .ser_sel(ser_sel), .ser_rw(ser_rw),
    .ser_addr(ser_addr), .ser_wdata(ser_wdata),
    .ser_busy(ser_busy), .ser_done(ser_done), .ser_rdata(ser_rdata),
    .busy(busy), .cmd_cnt(cmd_cnt)
  );

  // Standard-read FIFO A model: data appears the cycle after the read strobe.
  logic [31:0] fa_mem [0:63];
  int          fa_wr = 0;
  int          fa_rd = 0;
  assign FIFOA_empty = (fa_wr == fa_rd);
  always @(posedge CLK) begin
    if (FIFOA_ren) begin
      FIFOA_OUT <= fa_mem[fa_rd % 64];
      fa_rd     <= fa_rd + 1;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_b [$];
  logic [25:0] exp_ser [$];
  int          ren_log [$];
  int          ren_count = 0, wen_count = 0;
  int          last_ren_cyc = 0, last_start_cyc = 0, last_wen_cyc = 0;
  logic [15:0] stub_rdata = 16'h0;
  logic        stub_hang = 1'b0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_a(input logic [31:0] w);
    fa_mem[fa_wr % 64] = w;
    fa_wr = fa_wr + 1;
    $display("push FIFO A %h", w);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge CLK);
    while ((busy || !FIFOA_empty) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required idle", name, busy, n);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    logic [25:0] es;
    forever begin
      @(negedge CLK);
      if (FIFOA_ren) begin
        ren_count++;
        last_ren_cyc = cyc;
        ren_log.push_back(cyc);
        checks++;
        if (fa_rd > fa_wr) begin
          errors++;
          $display("FAIL fifoa_pop_empty: rd=%0d wr=%0d", fa_rd, fa_wr);
        end
      end
      if (FIFOB_wen) begin
        wen_count++;
        last_wen_cyc = cyc;
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL fifob_unexpected: got %h required no write", FIFOB_IN);
        end else begin
          e = exp_b.pop_front();
          if (FIFOB_IN !== e || FIFOB_full) begin
            errors++;
            $display("FAIL fifob_word: got %h full=%0b required %h full=0", FIFOB_IN, FIFOB_full, e);
          end else begin
            $display("ok   fifob_word: %h at cycle %0d", FIFOB_IN, cyc);
          end
        end
      end
      if (ser_start) begin
        last_start_cyc = cyc;
        checks++;
        if (exp_ser.size() == 0) begin
          errors++;
          $display("FAIL ser_unexpected: got %h required no start", {ser_sel, ser_rw, ser_addr, ser_wdata});
        end else begin
          es = exp_ser.pop_front();
          if ({ser_sel, ser_rw, ser_addr, ser_wdata} !== es) begin
            errors++;
            $display("FAIL ser_req: got %h required %h", {ser_sel, ser_rw, ser_addr, ser_wdata}, es);
          end else begin
            $display("ok   ser_req: sel=%0b rw=%0b addr=%h wdata=%h", ser_sel, ser_rw, ser_addr, ser_wdata);
          end
        end
      end
    end
  endtask

  // Stub master: busy from the start, ser_done 10 cycles after ser_start unless told to hang.
  task automatic stub_master();
    forever begin
      @(negedge CLK);
      if (ser_start) begin
        ser_busy = 1'b1;
        repeat (9) @(negedge CLK);
        if (!stub_hang) begin
          ser_rdata = stub_rdata;
          ser_done  = 1'b1;
        end
        @(negedge CLK);
        ser_done = 1'b0;
        ser_busy = 1'b0;
      end
    end
  endtask

  initial begin
    int w0, r0, lat, n, low_cnt;
    rst = 1'b1; run = 1'b0; FIFOB_full = 1'b0;
    sta_wei = 1'b0; sta_act = 1'b0;
    ser_busy = 1'b0; ser_done = 1'b0; ser_rdata = 16'h0;
    fork
      monitor();
      stub_master();
    join_none
    repeat (3) @(negedge CLK);
    check32("rst_fifob_in", FIFOB_IN, 32'h0);
    check32("rst_ctrl", {26'd0, FIFOA_ren, FIFOB_wen, ser_start, ser_sel, ser_rw, busy}, 32'h0);
    check32("rst_ser", {ser_addr, ser_wdata}, 32'h0);
    check32("rst_cmd_cnt", {16'd0, cmd_cnt}, 32'h0);
    rst = 1'b0;
    run = 1'b1;

    // Illegal opcode carries cmd_cnt at decode time
    exp_b.push_back(32'hE100_0000);
    push_a(32'h7000_0000);
    wait_idle("illegal", 40);
    exp_cnt = exp_cnt + 16'd1;
    check32("illegal_cmd_cnt", {16'd0, cmd_cnt}, {16'd0, exp_cnt});

    // Stray ser_done in IDLE must be ignored
    ser_done = 1'b1;
    @(negedge CLK);
    ser_done = 1'b0;
    repeat (3) @(negedge CLK);
    check32("stray_done", {15'd0, busy, cmd_cnt}, {16'd0, exp_cnt});

    // WRITE
    w0 = wen_count;
    exp_ser.push_back({1'b0, 1'b0, 8'h00, 16'h1234});
    push_a(32'h1000_1234);
    wait_idle("write", 60);
    exp_cnt = exp_cnt + 16'd1;
    check32("write_start_latency", 32'(last_start_cyc - last_ren_cyc), 32'd3);
    check32("write_cmd_cnt", {16'd0, cmd_cnt}, {16'd0, exp_cnt});
    check32("write_no_fifob", 32'(wen_count - w0), 32'd0);

    // READ on I2C
    stub_rdata = 16'hBEEF;
    exp_ser.push_back({1'b1, 1'b1, 8'h42, 16'h0000});
    exp_b.push_back(32'h2042_BEEF);
    push_a(32'h2842_0000);
    wait_idle("read", 60);
    exp_cnt = exp_cnt + 16'd1;
    check32("read_cmd_cnt", {16'd0, cmd_cnt}, {16'd0, exp_cnt});

    // DELAY 100 then MARK: fetch-to-write spans the delay plus command overhead
    ren_log.delete();
    exp_b.push_back(32'hF000_00AA);
    push_a(32'h5000_0064);
    push_a(32'hF000_00AA);
    wait_idle("delay", 300);
    exp_cnt = exp_cnt + 16'd2;
    lat = (ren_log.size() > 0) ? (last_wen_cyc - ren_log[0]) : -1;
    checks++;
    if (lat < 100 || lat > 108) begin
      errors++;
      $display("FAIL delay_latency: got %0d cycles required 100..108", lat);
    end else begin
      $display("ok   delay_latency: %0d cycles", lat);
    end
    check32("delay_cmd_cnt", {16'd0, cmd_cnt}, {16'd0, exp_cnt});

    // WAIT_WEI held low for 50 cycles, then released
    push_a(32'h3000_0000);
    repeat (4) @(negedge CLK);
    low_cnt = 0;
    repeat (50) begin
      @(negedge CLK);
      if (!busy) low_cnt++;
    end
    check32("wei_busy_held", 32'(low_cnt), 32'd0);
    check32("wei_cnt_hold", {16'd0, cmd_cnt}, {16'd0, exp_cnt});
    sta_wei = 1'b1;
    exp_cnt = exp_cnt + 16'd1;
    n = 0;
    while (cmd_cnt != exp_cnt && n < 10) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n > 4) begin
      errors++;
      $display("FAIL wei_release: got %0d cycles required <=4 (cmd_cnt=%0d)", n, cmd_cnt);
    end else begin
      $display("ok   wei_release: %0d cycles", n);
    end
    sta_wei = 1'b0;
    wait_idle("wei", 20);

`ifdef SEQ_TIMEOUT_EN
    exp_b.push_back({8'hE2, 8'h00, exp_cnt});
    push_a(32'h3000_0014);
    wait_idle("wei_timeout", 100);
    exp_cnt = exp_cnt + 16'd1;
    check32("wei_timeout_cnt", {16'd0, cmd_cnt}, {16'd0, exp_cnt});
`endif

    // MARK while FIFO B is full
    w0 = wen_count;
    FIFOB_full = 1'b1;
    exp_b.push_back(32'hF123_4567);
    push_a(32'hF123_4567);
    repeat (8) @(negedge CLK);
    check32("full_no_wen", 32'(wen_count - w0), 32'd0);
    check32("full_hold_data", FIFOB_IN, 32'hF123_4567);
    FIFOB_full = 1'b0;
    wait_idle("full", 20);
    exp_cnt = exp_cnt + 16'd1;
    check32("full_one_write", 32'(wen_count - w0), 32'd1);

    // Reset while the serial master never answers
    stub_hang = 1'b1;
    exp_ser.push_back({1'b0, 1'b0, 8'h00, 16'h5555});
    push_a(32'h1000_5555);
    n = 0;
    while (!ser_start && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check32("hang_start_seen", {31'd0, ser_start}, 32'd1);
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check32("rst2_fifob_in", FIFOB_IN, 32'h0);
    check32("rst2_ctrl", {26'd0, FIFOA_ren, FIFOB_wen, ser_start, ser_sel, ser_rw, busy}, 32'h0);
    check32("rst2_ser", {ser_addr, ser_wdata}, 32'h0);
    check32("rst2_cmd_cnt", {16'd0, cmd_cnt}, 32'h0);
    r0 = ren_count;
    push_a(32'hF000_0001);
    repeat (20) @(negedge CLK);
    check32("run_low_no_pop", {31'(ren_count - r0), busy}, 32'h0);
    check32("scoreboard_drained", 32'(exp_b.size() + exp_ser.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
